rr_arbiter: RTL and testbench

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter.sv | 92 +++++++++
 tb/tb_rr_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way request arbiter with registered one-hot grant.
//   MODE = 0 : fixed priority, highest-indexed request wins.
//   MODE = 1 : round robin, search starts at r_ptr and wraps.
//   HOLD = 1 : a granted requester keeps the grant while its req stays high.
// Ports:
//   clock     - rising-edge clock
//   reset     - synchronous active-high reset
//   en        - arbitration enable; low clears the grant, pointer kept
//   req[N]    - request vector, bit i = requester i
//   gnt[N]    - registered one-hot (or zero) grant
//   gnt_valid - registered, high iff gnt != 0
//   gnt_idx   - registered binary index of the grant, 0 when idle
//   req_up    - combinational en & |req
module rr_arbiter #(
   parameter int N    = 4,
   parameter int MODE = 1,
   parameter int HOLD = 0,
   localparam int IW  = $clog2(N)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          en,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic          gnt_valid,
   output logic [IW-1:0] gnt_idx,
   output logic          req_up
);

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0]  r_gnt;
   logic          r_vld;
   logic [IW-1:0] r_idx;
   logic [IW-1:0] r_ptr;

   logic          w_any;
   logic          w_hold;
   logic [IW-1:0] w_win;

   assign w_any  = |req;
   assign req_up = en & w_any;

   // Holding only applies while the current owner is still requesting.
   assign w_hold = (HOLD != 0) && r_vld && en && req[r_idx];

   always_comb begin : pick
      logic          found;
      logic [IW-1:0] cand;
      w_win = '0;
      found = 1'b0;
      cand  = '0;
      if (MODE == 0) begin
         // Ascending scan; the last hit is the highest index.
         for (int i = 0; i < N; i++)
            if (req[i]) w_win = IW'(i);
      end else begin
         // N is a power of two, so IW-bit addition wraps modulo N.
         for (int k = 0; k < N; k++) begin
            cand = r_ptr + IW'(k);
            if (!found && req[cand]) begin
               w_win = cand;
               found = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_gnt <= '0;
         r_vld <= 1'b0;
         r_idx <= '0;
         r_ptr <= '0;
      end else if (!en || (!w_hold && !w_any)) begin
         r_gnt <= '0;
         r_vld <= 1'b0;
         r_idx <= '0;
      end else if (!w_hold) begin
         r_gnt <= ONE << w_win;
         r_vld <= 1'b1;
         r_idx <= w_win;
         r_ptr <= (MODE == 0) ? '0 : w_win + IW'(1);
      end
      // Held grant: state left untouched, pointer does not advance.
   end

   assign gnt       = r_gnt;
   assign gnt_valid = r_vld;
   assign gnt_idx   = r_idx;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter (N=4): three instances share stimulus.
//   inst 0: MODE=1 HOLD=0, inst 1: MODE=0 HOLD=0, inst 2: MODE=1 HOLD=1.
module tb_rr_arbiter;
   localparam int N = 4;

   logic clock = 1'b0;
   logic reset, en;
   logic [N-1:0] req;
   logic [2:0][N-1:0] g;
   logic [2:0] gv;
   logic [2:0][1:0] gi;
   logic [2:0] ru;

   always #5 clock = ~clock;

   rr_arbiter #(.N(N), .MODE(1), .HOLD(0)) u_rr (.clock(clock), .reset(reset), .en(en), .req(req),
      .gnt(g[0]), .gnt_valid(gv[0]), .gnt_idx(gi[0]), .req_up(ru[0]));
   rr_arbiter #(.N(N), .MODE(0), .HOLD(0)) u_fp (.clock(clock), .reset(reset), .en(en), .req(req),
      .gnt(g[1]), .gnt_valid(gv[1]), .gnt_idx(gi[1]), .req_up(ru[1]));
   rr_arbiter #(.N(N), .MODE(1), .HOLD(1)) u_hd (.clock(clock), .reset(reset), .en(en), .req(req),
      .gnt(g[2]), .gnt_valid(gv[2]), .gnt_idx(gi[2]), .req_up(ru[2]));

   typedef struct packed {
      logic [2:0][N-1:0] gnt;
      logic [2:0]        vld;
      logic [2:0][1:0]   idx;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_err = 0;

   int         m_ptr [3];
   logic [3:0] m_gnt [3];
   logic [1:0] m_idx [3];
   logic       m_vld [3];
   int         wt    [N];

   function automatic bit mode_of(input int k); return k != 1; endfunction
   function automatic bit hold_of(input int k); return k == 2; endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour of one instance for the inputs about to be clocked.
   task automatic model_step(input int k);
      int w;
      if (reset) begin
         m_ptr[k] = 0; m_gnt[k] = '0; m_idx[k] = '0; m_vld[k] = 1'b0;
         return;
      end
      if (hold_of(k) && m_vld[k] && en && req[m_idx[k]]) return;
      if (!en || req == '0) begin
         m_gnt[k] = '0; m_idx[k] = '0; m_vld[k] = 1'b0;
         return;
      end
      w = -1;
      if (!mode_of(k)) begin
         for (int i = N-1; i >= 0; i--)
            if (req[i]) begin w = i; break; end
      end else begin
         for (int s = 0; s < N; s++)
            if (req[(m_ptr[k] + s) % N]) begin w = (m_ptr[k] + s) % N; break; end
      end
      m_gnt[k] = 4'b0001 << w;
      m_idx[k] = w[1:0];
      m_vld[k] = 1'b1;
      m_ptr[k] = mode_of(k) ? (w + 1) % N : 0;
   endtask

   // One clock: drive, check req_up, push prediction, clock, pop and compare.
   task automatic cyc(input logic r, input logic e, input logic [N-1:0] rq);
      exp_t x, y;
      reset = r; en = e; req = rq;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("req_up%0d", k), ru[k], e & (|rq));
         model_step(k);
         x.gnt[k] = m_gnt[k];
         x.vld[k] = m_vld[k];
         x.idx[k] = m_idx[k];
      end
      sb.push_back(x);
      @(posedge clock);
      #1;
      y = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("gnt%0d", k), g[k], y.gnt[k]);
         chk($sformatf("vld%0d", k), gv[k], y.vld[k]);
         chk($sformatf("idx%0d", k), gi[k], y.idx[k]);
         chk($sformatf("onehot%0d", k), $onehot0(g[k]), 1);
         chk($sformatf("subset%0d", k), g[k] & ~rq, 0);
      end
   endtask

   // Literal expectations taken straight from the directed vectors.
   task automatic lit(input int k, input logic [N-1:0] eg, input logic [1:0] ei, input string tag);
      chk({tag, "_gnt"}, g[k], eg);
      chk({tag, "_idx"}, gi[k], ei);
      chk({tag, "_vld"}, gv[k], eg != '0);
   endtask

   initial begin
      logic [N-1:0] rr_seq [5];
      logic [N-1:0] r;
      logic e;
      rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      // Reset state
      cyc(1'b1, 1'b1, 4'b1111);
      cyc(1'b1, 1'b0, 4'b0000);
      for (int k = 0; k < 3; k++) lit(k, 4'b0000, 2'd0, "rst");

      // Round robin over all four requesters
      for (int c = 0; c < 5; c++) begin
         cyc(1'b0, 1'b1, 4'b1111);
         lit(0, rr_seq[c], 2'(c % 4), $sformatf("rr%0d", c));
      end

      // Fixed priority, then enable low
      cyc(1'b1, 1'b0, 4'b0000);
      for (int c = 0; c < 3; c++) begin
         cyc(1'b0, 1'b1, 4'b0110);
         lit(1, 4'b0100, 2'd2, "fp");
         chk("fp_req_up", ru[1], 1);
      end
      cyc(1'b0, 1'b0, 4'b0110);
      lit(1, 4'b0000, 2'd0, "fp_en0");
      chk("fp_req_up_en0", ru[1], 0);

      // Hold, then owner drops its request
      cyc(1'b1, 1'b0, 4'b0000);
      for (int c = 0; c < 3; c++) begin
         cyc(1'b0, 1'b1, 4'b0011);
         lit(2, 4'b0001, 2'd0, "hold");
      end
      cyc(1'b0, 1'b1, 4'b0010);
      lit(2, 4'b0010, 2'd1, "hold_rel");

      // Pointer wrap from 3 to 0
      cyc(1'b1, 1'b0, 4'b0000);
      cyc(1'b0, 1'b1, 4'b0100);
      lit(0, 4'b0100, 2'd2, "wrap_a");
      cyc(1'b0, 1'b1, 4'b1001);
      lit(0, 4'b1000, 2'd3, "wrap_b");
      cyc(1'b0, 1'b1, 4'b1001);
      lit(0, 4'b0001, 2'd0, "wrap_c");

      // Reset during a held grant
      cyc(1'b1, 1'b0, 4'b0000);
      cyc(1'b0, 1'b1, 4'b0100);
      cyc(1'b0, 1'b1, 4'b0100);
      lit(2, 4'b0100, 2'd2, "mid_hold");
      cyc(1'b1, 1'b1, 4'b0100);
      lit(2, 4'b0000, 2'd0, "mid_rst");
      cyc(1'b0, 1'b1, 4'b1111);
      lit(2, 4'b0001, 2'd0, "post_rst");

      // en low and empty req keep the pointer
      cyc(1'b1, 1'b0, 4'b0000);
      cyc(1'b0, 1'b1, 4'b0001);
      lit(0, 4'b0001, 2'd0, "ptr_a");
      cyc(1'b0, 1'b0, 4'b1111);
      lit(0, 4'b0000, 2'd0, "ptr_en0");
      cyc(1'b0, 1'b1, 4'b0000);
      lit(0, 4'b0000, 2'd0, "ptr_idle");
      cyc(1'b0, 1'b1, 4'b1111);
      lit(0, 4'b0010, 2'd1, "ptr_b");

      // Random sticky requests with starvation tracking on the RR instance
      for (int i = 0; i < N; i++) wt[i] = 0;
      r = 4'b0000;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(3) == 0) r[i] = ~r[i];
         e = ($urandom_range(9) != 0);
         cyc(1'b0, e, r);
         for (int i = 0; i < N; i++) begin
            if (!r[i]) wt[i] = 0;
            else if (e) begin
               if (g[0][i]) wt[i] = 0;
               else begin
                  wt[i]++;
                  chk($sformatf("starve%0d", i), wt[i] <= N-1, 1);
               end
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
